// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the binary (Stein) GCD engine.
//   gcd_state_e : FSM state encoding (IDLE, STRIP, ITER, DONE)
//   gcd_cnt_w() : default width of the optional cycle counter, sized to hold
//                 the worst-case accept-to-result latency of 3*WIDTH+3.
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STRIP = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } gcd_state_e;

  function automatic int gcd_cnt_w(input int width);
    return $clog2(3 * width + 3);
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// gcd_stein_step: one combinational ITER step of Stein's algorithm.
//   a_i, b_i     : current operands (WIDTH bits, both non-zero, not both even)
//   next_a_o/b_o : operands after one reduction step
//   eq_o         : a_i == b_i, the loop terminates and a_i is the odd part
// Priority: equal, a even, b even, then subtract-and-halve on the larger one.
// The larger operand is always the minuend, so the subtract never wraps; the
// difference of two odd numbers is even, so the halving loses nothing.
module gcd_stein_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] next_a_o,
  output logic [WIDTH-1:0] next_b_o,
  output logic             eq_o
);

  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  assign a_minus_b = a_i - b_i;
  assign b_minus_a = b_i - a_i;
  assign eq_o      = (a_i == b_i);

  always_comb begin
    next_a_o = a_i;
    next_b_o = b_i;
    if (eq_o) begin
      next_a_o = a_i;
    end else if (!a_i[0]) begin
      next_a_o = a_i >> 1;
    end else if (!b_i[0]) begin
      next_b_o = b_i >> 1;
    end else if (a_i > b_i) begin
      next_a_o = a_minus_b >> 1;
    end else begin
      next_b_o = b_minus_a >> 1;
    end
  end

endmodule

// File: rtl/gcd_stein.sv
// gcd_stein: parametrised binary (Stein) GCD engine with valid/ready on both
// the operand and result sides.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake; x, y sampled only on accept
//   out_valid/out_ready : result handshake; result held stable until consumed
//   result              : gcd(x, y) (gcd(0,0) = 0)
//   busy                : high in every state except IDLE
//   cycles              : STRIP+ITER cycle count of the last/current run,
//                         present only when GCD_CYCLE_COUNT_EN is defined
// Flow: IDLE -> (zero operand: DONE) | STRIP (strip common factors of two,
// counted in k) -> ITER (odd-part reduction) -> DONE (result = a << k).
module gcd_stein
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = gcd_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);

  localparam int KW = $clog2(WIDTH);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] step_a, step_b;
  logic             step_eq;

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cycles = cnt_q;
`endif

  gcd_stein_step #(.WIDTH(WIDTH)) u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .next_a_o (step_a),
    .next_b_o (step_b),
    .eq_o     (step_eq)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
`ifdef GCD_CYCLE_COUNT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_d = x;
          b_d = y;
          k_d = '0;
`ifdef GCD_CYCLE_COUNT_EN
          cnt_d = '0;
`endif
          // gcd(0, v) = v covers both-zero too (result 0).
          if (x == '0) begin
            res_d   = y;
            state_d = S_DONE;
          end else if (y == '0) begin
            res_d   = x;
            state_d = S_DONE;
          end else begin
            state_d = S_STRIP;
          end
        end
      end
      S_STRIP: begin
`ifdef GCD_CYCLE_COUNT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // Both operands are non-zero here, so this loop ends within WIDTH-1
        // shifts and k cannot overflow.
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + 1'b1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
`ifdef GCD_CYCLE_COUNT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (step_eq) begin
          // Restore the common power of two; never exceeds the inputs.
          res_d   = a_q << k_q;
          state_d = S_DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
`ifdef GCD_CYCLE_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: directed-vector bench for gcd_stein (WIDTH=16 main instance,
// plus a WIDTH=4 instance sharing the handshake for the 4-bit vector).
// Latency is counted in edges, the accept edge being edge 1.
module tb_gcd_stein;

  localparam int W     = 16;
  localparam int BOUND = 3 * W + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x, y;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          busy;

  logic          in_ready4, out_valid4, busy4;
  logic [3:0]    result4;

`ifdef GCD_CYCLE_COUNT_EN
  logic [5:0]    cycles;
  logic [3:0]    cycles4;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gcd_stein #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles    (cycles)
`endif
  );

  gcd_stein #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .x         (x[3:0]),
    .y         (y[3:0]),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .result    (result4),
    .busy      (busy4)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles    (cycles4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands for one edge (engine must be idle).
  task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] ya);
    x        = xa;
    y        = ya;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; returns edges until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat <= BOUND + 5) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya,
                     input logic [W-1:0] exp, input int exp_lat);
    int lat;
    accept(xa, ya);
    wait_out(lat);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_bound"}, lat <= BOUND, 1);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    consume();
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("rst_cycles", cycles, 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // (12, 15): a 12->6->3, b 15->6->3; both widths share the same trace.
    accept(16'd12, 16'd15);
    wait_out(lat);
    chk("w16_12_15_res", result, 3);
    chk("w16_12_15_lat", lat, 7);
    chk("w4_12_15_valid", out_valid4, 1);
    chk("w4_12_15_res", result4, 3);
`ifdef GCD_CYCLE_COUNT_EN
    chk("w16_12_15_cycles", cycles, 6);
    chk("w4_12_15_cycles", cycles4, 6);
`endif
    consume();

    run("g48_18", 16'd48, 16'd18, 16'd6, 0);
    run("g0_9", 16'd0, 16'd9, 16'd9, 1);
    run("g9_0", 16'd9, 16'd0, 16'd9, 1);
    run("g0_0", 16'd0, 16'd0, 16'd0, 1);
    run("gmax_eq", 16'd65535, 16'd65535, 16'd65535, 3);
    run("g_pow2", 16'd32768, 16'd16384, 16'd16384, 0);
    run("g_primes", 16'd65521, 16'd65519, 16'd1, 0);
    run("g_mix", 16'd1071, 16'd462, 16'd21, 0);

    // Backpressure: result held, new operands ignored while DONE.
    accept(16'd48, 16'd18);
    wait_out(lat);
    x        = 16'd7;
    y        = 16'd21;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_res", result, 6);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;                 // edge F: result consumed
    out_ready = 1'b0;
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_in_ready", in_ready, 1);
    @(posedge clk); #1;                 // edge F+1: held operands accepted
    in_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    wait_out(lat);
    chk("bp_next_res", result, 7);
    consume();

    // Reset in the middle of ITER discards the run.
    accept(16'd65521, 16'd65519);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_res", result, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("mid_rst_cycles", cycles, 0);
`endif
    run("post_rst", 16'd12, 16'd15, 16'd3, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_stein.md
# gcd_stein

Parametrised binary (Stein) GCD engine; successor to the fixed 4-bit subtractive GCD. It computes gcd(x, y) for unsigned WIDTH-bit operands using shifts and subtracts only, with valid/ready handshakes on both the operand and result sides. It serves as the reusable GCD/coprimality primitive for key-generation and modular-inverse datapaths in the HE hardware.

## Interface
- WIDTH, 16: operand and result width in bits (≥2).
- CNT_W, $clog2(3*WIDTH+3): width of the optional cycle counter.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands present on x/y.
- in_ready  out  1  engine idle, operands accepted this cycle if in_valid.
- x  in  WIDTH  operand A, unsigned.
- y  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  gcd(x, y).
- busy  out  1  high in every state except IDLE.
- cycles  out  CNT_W  present only with GCD_CYCLE_COUNT_EN.

## Operation
- State machine: IDLE, STRIP, ITER, DONE. Internal a, b (WIDTH each), k (shift count, $clog2(WIDTH) bits).
- IDLE: in_ready=1. On in_valid: a←x, b←y, k←0.
  - x==0: result←y, go DONE.
  - y==0 (x≠0): result←x, go DONE.
  - x==0 and y==0: result←0, go DONE.
  - Otherwise go STRIP.
- STRIP, one step per cycle: while a[0]==0 and b[0]==0, shift both right by 1 and increment k. Otherwise go ITER without modifying a or b.
- ITER, exactly one action per cycle, in priority order:
  - a==b: result←a<<k, go DONE.
  - a even: a←a>>1.
  - b even: b←b>>1.
  - a>b, both odd: a←(a−b)>>1.
  - b>a, both odd: b←(b−a)>>1.
- Subtraction is WIDTH bits and never underflows, since the larger operand is always the minuend. a<<k never exceeds the original operand, so there is no overflow.
- DONE: out_valid=1, result stable. When out_ready=1, go IDLE and drop out_valid in the same edge.
- Inputs x and y are sampled only at the accept edge. Later changes are ignored.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, cycles=0.
- Reset asserted in any state: the computation is discarded and the registers are forced to their reset values at the next edge. No result is produced.
- Accept at edge E with a zero operand: out_valid is high after edge E+1.
- x==y (non-zero, not both even): STRIP 1 cycle, ITER 1 cycle, so out_valid is high after E+3.
- General latency is data-dependent, bounded by 3*WIDTH+3 cycles from accept to out_valid.
- Back-to-back operation: out_valid&&out_ready at edge F gives in_ready=1 after F. The next accept is possible at F+1. There is no same-cycle turnaround.
- in_valid while busy is ignored. No queueing.

## Configuration
- GCD_CYCLE_COUNT_EN defined:
  - `cycles` port exists.
  - The counter clears on accept and increments every cycle in STRIP and ITER.
  - It is frozen in DONE and valid while out_valid is high.
- Undefined: no `cycles` port and no counter logic. All other behaviour is identical.

## Structure
- Package gcd_pkg: state encoding (IDLE, STRIP, ITER, DONE) and a function for the default CNT_W.
- One sub-module, gcd_stein_step: combinational ITER datapath. It takes a, b and returns next_a, next_b, and eq. The FSM, k, and handshake stay in gcd_stein.

## Test plan
- WIDTH=4, x=12, y=15 → result=3. Trace a: 12→6→3; b: 15→6→3. out_valid after E+7.
- WIDTH=16, x=48, y=18 → result=6, k=1. x=0, y=9 → result=9 with out_valid after E+1. Both zero → result 0.
- WIDTH=16, x=65535, y=65535 → 65535. x=32768, y=16384 → 16384. x=65521, y=65519 → 1. Each within the 51-cycle bound.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and result stay constant and in_valid is ignored. Release, then verify the next operand pair is accepted one cycle later.
- Reset asserted mid-ITER on a (65521, 65519) run → next cycle state IDLE, out_valid=0, result=0. A fresh (12, 15) then yields 3.
- With GCD_CYCLE_COUNT_EN: (12, 15) → cycles=6. Without the macro the build has no `cycles` port and results match.
